wr_addr_gen: RTL and testbench
==============================

WR_ADDR_GEN -- requirements
Module: wr_addr_gen

Interface
REQ-001 Parameters, one per line (name, default, meaning): A_WID, 8, address width; N_OFF, 3, offset slots per row; C_WID, 2, cycle-select width (2^C_WID > N_OFF); LOAD_LEN, 256, load-mode words before address wrap (2..2^A_WID).
REQ-002 Ports, one per line (name, direction, width, meaning): clk, in, 1, single clock, rising edge; reset_n, in, 1, asynchronous active-low reset.
REQ-003 fsm, in, 4, one-hot controller state (bit1 = LOAD, bit2 = UPDATE); wr_en, in, 1, update-mode write request; sin, in, 1, load-mode write strobe.
REQ-004 cycle, in, C_WID, offset slot select; base_addr, in, A_WID, row base address; addr_offset, in, N_OFF*A_WID, packed offsets, slot 1 in MSBs; z_size, in, A_WID, circulant size (1..2^A_WID-1).
REQ-005 wr_addr, out, A_WID, RAM write address; ram_wr, out, 1, RAM write enable; load_done, out, 1, one-cycle pulse at load wrap; cfg_err, out, 1, sticky configuration error.

Function
REQ-006 Mode: LOAD when fsm[1]=1 (priority over fsm[2]); UPDATE when fsm[1]=0 and fsm[2]=1; IDLE otherwise. Mode is sampled every clk; all outputs are registered with 1-cycle latency.
REQ-007 Internal state: load counter lcnt (A_WID bits), rotation counter rot (A_WID bits), previous mode register.
REQ-008 LOAD: ram_wr <= sin; when ram_wr=1, wr_addr advances by 1 and lcnt advances by 1.
REQ-009 LOAD wrap: when ram_wr=1 and lcnt=LOAD_LEN-1, wr_addr <= 0 and lcnt <= 0, and load_done pulses high for exactly 1 cycle. Otherwise load_done=0.
REQ-010 UPDATE offset select: cycle=k (1..N_OFF) selects slot k, where slot 1 is addr_offset[N_OFF*A_WID-1 -: A_WID] and slot k is the k-th A_WID field from the MSB. cycle=0 or cycle>N_OFF selects offset 0.
REQ-011 UPDATE rotation: s = off + rot, computed at A_WID+1 bits; if s >= z_size then s = s - z_size.
REQ-012 UPDATE address: when wr_en=1, wr_addr <= (base_addr + s) mod 2^A_WID; when wr_en=0, wr_addr <= 0. ram_wr <= wr_en in all cases.
REQ-013 rot advances by 1 on each UPDATE cycle with wr_en=1 and cycle=N_OFF (end of row). It wraps to 0 when the increment would reach z_size.
REQ-014 rot clears to 0 on entry to UPDATE from any other mode. lcnt clears to 0 on entry to LOAD from any other mode. wr_addr is not cleared on LOAD entry except by REQ-016.
REQ-015 IDLE: wr_addr <= 0, ram_wr <= 0, load_done <= 0; rot and lcnt hold.
REQ-016 On any LOAD entry from IDLE or UPDATE, wr_addr <= 0 on the entry cycle, regardless of sin.
REQ-017 cfg_err is set when, in UPDATE with wr_en=1, either the selected off >= z_size, or cycle > N_OFF, or z_size = 0. The write still occurs, using a reduced s (single subtraction) or s = 0 if z_size = 0.
REQ-018 cfg_err holds until the next IDLE cycle, which clears it; it is never cleared mid-UPDATE.
REQ-019 Mode switch mid-operation takes effect on the next edge with no extra latency; no partial state carries across except as stated in REQ-014 to REQ-016.

Reset
REQ-020 While reset_n=0 (asynchronous assert): wr_addr=0, ram_wr=0, load_done=0, cfg_err=0, lcnt=0, rot=0, previous mode = IDLE.
REQ-021 Deassertion is synchronised externally; the first active edge after release behaves as if the previous mode were IDLE.
REQ-022 Reset asserted mid-LOAD or mid-UPDATE aborts immediately; no write pulse survives the reset.

Verification (A_WID=8, N_OFF=3, C_WID=2, LOAD_LEN=4 unless stated)
REQ-023 LOAD with sin=1 for 6 cycles -> ram_wr high from cycle 1; wr_addr 0,1,2,3,0,1; load_done pulses once, on the 3->0 transition.
REQ-024 UPDATE with base=0x20, addr_offset={0x05,0x02,0x07}, z_size=8, wr_en=1, cycle 1,2,3 repeated twice -> row 1 wr_addr 0x25,0x22,0x27; row 2 (rot=1) wr_addr 0x26,0x23,0x20.
REQ-025 base=0xFE, offset slot1=0x03, z_size=8, cycle=1 -> wr_addr=0x01 (mod-256 wrap); cycle=0 -> wr_addr=0xFE.
REQ-026 offset slot2=0x09 with z_size=8 in UPDATE -> cfg_err=1, which holds through UPDATE and clears after one IDLE cycle.
REQ-027 fsm=0b0110 with sin=0 and wr_en=1 -> LOAD wins; ram_wr=0 and no UPDATE address is produced.
REQ-028 reset_n pulsed low mid-UPDATE, between clock edges -> all outputs 0 immediately; after release, rot restarts at 0.

Source files
------------

// File: rtl/wr_addr_gen_if.sv
// Bus bundle for the write-address generator: controller-side inputs
// (mode, strobes, row configuration) and the RAM-side write port.
interface wr_addr_gen_if #(
  parameter int A_WID = 8,
  parameter int N_OFF = 3,
  parameter int C_WID = 2
);
  logic [3:0]             fsm;
  logic                   wr_en;
  logic                   sin;
  logic [C_WID-1:0]       cycle;
  logic [A_WID-1:0]       base_addr;
  logic [N_OFF*A_WID-1:0] addr_offset;
  logic [A_WID-1:0]       z_size;
  logic [A_WID-1:0]       wr_addr;
  logic                   ram_wr;
  logic                   load_done;
  logic                   cfg_err;

  // Controller side: drives mode/config, observes the write port.
  modport master (
    output fsm, wr_en, sin, cycle, base_addr, addr_offset, z_size,
    input  wr_addr, ram_wr, load_done, cfg_err
  );

  // Generator side.
  modport slave (
    input  fsm, wr_en, sin, cycle, base_addr, addr_offset, z_size,
    output wr_addr, ram_wr, load_done, cfg_err
  );
endinterface

// File: rtl/wr_addr_gen.sv
// RAM write-address generator with two modes:
//   LOAD   - sequential addresses 0..LOAD_LEN-1 on each strobe, wrapping with
//            a one-cycle load_done pulse.
//   UPDATE - base_addr plus a per-slot offset cyclically rotated inside a
//            circulant of size z_size; the rotation steps once per row.
// All outputs are registered (one cycle after the inputs are presented).
module wr_addr_gen #(
  parameter int A_WID    = 8,
  parameter int N_OFF    = 3,
  parameter int C_WID    = 2,
  parameter int LOAD_LEN = 256
) (
  input  logic           clk,
  input  logic           reset_n,
  wr_addr_gen_if.slave   bus
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_LOAD   = 2'd1,
    MODE_UPDATE = 2'd2
  } mode_e;

  localparam logic [A_WID-1:0] LOAD_LAST = A_WID'(LOAD_LEN - 1);

  mode_e            mode;
  mode_e            prev_mode_q, prev_mode_d;
  logic [A_WID-1:0] wr_addr_q,   wr_addr_d;
  logic             ram_wr_q,    ram_wr_d;
  logic             load_done_q, load_done_d;
  logic             cfg_err_q,   cfg_err_d;
  logic [A_WID-1:0] lcnt_q,      lcnt_d;
  logic [A_WID-1:0] rot_q,       rot_d;

  // UPDATE datapath intermediates.
  logic [A_WID-1:0] off_sel;
  logic [A_WID-1:0] rot_cur;
  logic [A_WID-1:0] rot_next;
  logic [A_WID:0]   rot_inc;
  logic [A_WID:0]   sum;
  logic [A_WID-1:0] upd_addr;
  logic             upd_err;
  logic             end_of_row;

  // Only the LOAD and UPDATE bits of the one-hot state are meaningful here.
  logic unused_fsm_bits;
  assign unused_fsm_bits = &{1'b0, bus.fsm[3], bus.fsm[0]};

  // Decode the operating mode; LOAD outranks UPDATE.
  always_comb begin
    mode = MODE_IDLE;
    if (bus.fsm[1])      mode = MODE_LOAD;
    else if (bus.fsm[2]) mode = MODE_UPDATE;
  end

  // Rotated offset and write address for UPDATE mode.
  always_comb begin
    off_sel = '0;
    for (int k = 1; k <= N_OFF; k++) begin
      if (int'(bus.cycle) == k) off_sel = bus.addr_offset[(N_OFF-k+1)*A_WID-1 -: A_WID];
    end
    end_of_row = (int'(bus.cycle) == N_OFF);
    // Rotation restarts from zero on the first UPDATE cycle.
    rot_cur    = (prev_mode_q == MODE_UPDATE) ? rot_q : '0;
    rot_inc    = {1'b0, rot_cur} + 1'b1;
    rot_next   = (rot_inc == {1'b0, bus.z_size}) ? '0 : rot_inc[A_WID-1:0];
    sum        = {1'b0, off_sel} + {1'b0, rot_cur};
    if (bus.z_size == '0)                sum = '0;
    else if (sum >= {1'b0, bus.z_size})  sum = sum - {1'b0, bus.z_size};
    // The top bit of sum is dropped: the address wraps modulo 2^A_WID.
    upd_addr   = bus.base_addr + sum[A_WID-1:0];
    upd_err    = (off_sel >= bus.z_size) || (int'(bus.cycle) > N_OFF) ||
                 (bus.z_size == '0);
  end

  // Next-state logic for every register, selected by mode.
  // NOTE: every _d gets a default before the case, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    prev_mode_d = mode;
    wr_addr_d   = wr_addr_q;
    ram_wr_d    = 1'b0;
    load_done_d = 1'b0;
    cfg_err_d   = cfg_err_q;
    lcnt_d      = lcnt_q;
    rot_d       = rot_q;
    unique case (mode)
      MODE_LOAD: begin
        ram_wr_d = bus.sin;
        if (prev_mode_q != MODE_LOAD) begin
          lcnt_d    = '0;
          wr_addr_d = '0;
        end else if (ram_wr_q) begin
          // The word just written was at lcnt_q; step past it.
          if (lcnt_q == LOAD_LAST) begin
            lcnt_d      = '0;
            wr_addr_d   = '0;
            load_done_d = 1'b1;
          end else begin
            lcnt_d    = lcnt_q + 1'b1;
            wr_addr_d = wr_addr_q + 1'b1;
          end
        end
      end
      MODE_UPDATE: begin
        ram_wr_d  = bus.wr_en;
        wr_addr_d = bus.wr_en ? upd_addr : '0;
        rot_d     = (bus.wr_en && end_of_row) ? rot_next : rot_cur;
        if (bus.wr_en && upd_err) cfg_err_d = 1'b1;
      end
      default: begin
        wr_addr_d = '0;
        cfg_err_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any write in flight.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_mode_q <= MODE_IDLE;
      wr_addr_q   <= '0;
      ram_wr_q    <= 1'b0;
      load_done_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      lcnt_q      <= '0;
      rot_q       <= '0;
    end else begin
      prev_mode_q <= prev_mode_d;
      wr_addr_q   <= wr_addr_d;
      ram_wr_q    <= ram_wr_d;
      load_done_q <= load_done_d;
      cfg_err_q   <= cfg_err_d;
      lcnt_q      <= lcnt_d;
      rot_q       <= rot_d;
    end
  end

  assign bus.wr_addr   = wr_addr_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.load_done = load_done_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_wr_addr_gen.sv
// Bench for wr_addr_gen (A_WID=8, N_OFF=3, C_WID=2, LOAD_LEN=4): directed
// vector table, reset-abort sequence, then randomized traffic against a
// count-based reference model.
module tb_wr_addr_gen;

  localparam int A_WID    = 8;
  localparam int N_OFF    = 3;
  localparam int C_WID    = 2;
  localparam int LOAD_LEN = 4;

  logic clk;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  wr_addr_gen_if #(.A_WID(A_WID), .N_OFF(N_OFF), .C_WID(C_WID)) bus ();

  wr_addr_gen #(
    .A_WID(A_WID), .N_OFF(N_OFF), .C_WID(C_WID), .LOAD_LEN(LOAD_LEN)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  fsm;
    logic        wr_en;
    logic        sin;
    logic [1:0]  cyc;
    logic [7:0]  base;
    logic [23:0] off;
    logic [7:0]  z;
    logic [7:0]  e_addr;
    logic        e_wr;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  // Reference model state.
  int m_prev;   // 0 idle, 1 load, 2 update
  int m_words;  // writes completed since LOAD entry
  int m_rows;   // rows completed since UPDATE entry
  int e_addr;
  int e_wr;
  int e_done;
  int e_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] fsm, input logic wr_en, input logic sin,
                              input logic [1:0] cyc, input logic [7:0] base,
                              input logic [23:0] off, input logic [7:0] z,
                              input logic [7:0] ea, input logic ew, input logic ed,
                              input logic ee);
    vec_t v;
    v.fsm = fsm; v.wr_en = wr_en; v.sin = sin; v.cyc = cyc; v.base = base;
    v.off = off; v.z = z; v.e_addr = ea; v.e_wr = ew; v.e_done = ed; v.e_err = ee;
    return v;
  endfunction

  task automatic drive(input logic [3:0] fsm, input logic wr_en, input logic sin,
                       input logic [1:0] cyc, input logic [7:0] base,
                       input logic [23:0] off, input logic [7:0] z);
    bus.fsm = fsm; bus.wr_en = wr_en; bus.sin = sin; bus.cycle = cyc;
    bus.base_addr = base; bus.addr_offset = off; bus.z_size = z;
  endtask

  task automatic check_all(input string tag, input int ea, input int ew, input int ed, input int ee);
    check({tag, "_addr"}, 32'(bus.wr_addr),   32'(ea));
    check({tag, "_wr"},   32'(bus.ram_wr),    32'(ew));
    check({tag, "_done"}, 32'(bus.load_done), 32'(ed));
    check({tag, "_err"},  32'(bus.cfg_err),   32'(ee));
  endtask

  task automatic model_reset();
    m_prev = 0; m_words = 0; m_rows = 0;
    e_addr = 0; e_wr = 0; e_done = 0; e_err = 0;
  endtask

  // Expected outputs after the coming edge, from the inputs now on the bus.
  task automatic model_step();
    int mode, z, cyc, off, rot, s;
    mode = bus.fsm[1] ? 1 : (bus.fsm[2] ? 2 : 0);
    z    = int'(bus.z_size);
    cyc  = int'(bus.cycle);
    if (mode == 1) begin
      if (m_prev != 1) begin
        m_words = 0; e_addr = 0; e_done = 0;
      end else if (e_wr != 0) begin
        m_words++;
        e_addr = m_words % LOAD_LEN;
        e_done = (e_addr == 0) ? 1 : 0;
      end else begin
        e_done = 0;
      end
      e_wr = int'(bus.sin);
    end else if (mode == 2) begin
      if (m_prev != 2) m_rows = 0;
      rot = (z == 0) ? 0 : m_rows % z;
      off = (cyc >= 1 && cyc <= N_OFF) ? int'((bus.addr_offset >> (8 * (N_OFF - cyc))) & 24'hFF) : 0;
      s = off + rot;
      if (z == 0) s = 0;
      else if (s >= z) s = s - z;
      e_addr = bus.wr_en ? (int'(bus.base_addr) + s) % 256 : 0;
      e_wr   = int'(bus.wr_en);
      e_done = 0;
      if (bus.wr_en && (off >= z || cyc > N_OFF || z == 0)) e_err = 1;
      if (bus.wr_en && cyc == N_OFF) m_rows++;
    end else begin
      e_addr = 0; e_wr = 0; e_done = 0; e_err = 0;
    end
    m_prev = mode;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    automatic logic [23:0] o1 = 24'h050207;
    automatic logic [23:0] o2 = 24'h030207;
    automatic logic [23:0] o3 = 24'h050907;
    int cur_mode;
    int z;
    logic [23:0] offs;
    logic [3:0] f;

    // ---------------- reset state ----------------
    reset_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, o1, 8'd8);
    #2;
    check_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // ---------------- directed vector table ----------------
    // LOAD, sin=1 for 6 cycles: 0,1,2,3,0,1 with load_done on the wrap.
    vecs.push_back(mk(4'b0010, 0, 1, 0, 8'h00, o1, 8, 8'h00, 1, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 8'h00, o1, 8, 8'h01, 1, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 8'h00, o1, 8, 8'h02, 1, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 8'h00, o1, 8, 8'h03, 1, 0, 0));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 8'h00, o1, 8, 8'h00, 1, 1, 0));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 8'h00, o1, 8, 8'h01, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 8'h00, o1, 8, 8'h00, 0, 0, 0));
    // Two UPDATE rows, rotation 0 then 1.
    vecs.push_back(mk(4'b0100, 1, 0, 1, 8'h20, o1, 8, 8'h25, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 2, 8'h20, o1, 8, 8'h22, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 3, 8'h20, o1, 8, 8'h27, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 1, 8'h20, o1, 8, 8'h26, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 2, 8'h20, o1, 8, 8'h23, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 3, 8'h20, o1, 8, 8'h20, 1, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 8'h00, o1, 8, 8'h00, 0, 0, 0));
    // Modulo-256 wrap, cycle=0 selects zero offset, wr_en=0 gives address 0.
    vecs.push_back(mk(4'b0100, 1, 0, 1, 8'hFE, o2, 8, 8'h01, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 1, 0, 0, 8'hFE, o2, 8, 8'hFE, 1, 0, 0));
    vecs.push_back(mk(4'b0100, 0, 0, 1, 8'hFE, o2, 8, 8'h00, 0, 0, 0));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 8'h00, o2, 8, 8'h00, 0, 0, 0));
    // Offset 9 >= z_size 8: sticky cfg_err, reduced offset 1, cleared by IDLE.
    vecs.push_back(mk(4'b0100, 1, 0, 2, 8'h20, o3, 8, 8'h21, 1, 0, 1));
    vecs.push_back(mk(4'b0100, 1, 0, 1, 8'h20, o3, 8, 8'h25, 1, 0, 1));
    vecs.push_back(mk(4'b0100, 0, 0, 1, 8'h20, o3, 8, 8'h00, 0, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 8'h00, o3, 8, 8'h00, 0, 0, 0));
    // fsm=0110: LOAD wins over UPDATE; no write without sin.
    vecs.push_back(mk(4'b0110, 1, 0, 1, 8'h20, o1, 8, 8'h00, 0, 0, 0));
    vecs.push_back(mk(4'b0110, 1, 0, 1, 8'h20, o1, 8, 8'h00, 0, 0, 0));
    vecs.push_back(mk(4'b0110, 1, 1, 1, 8'h20, o1, 8, 8'h00, 1, 0, 0));
    vecs.push_back(mk(4'b0110, 1, 1, 1, 8'h20, o1, 8, 8'h01, 1, 0, 0));
    // z_size=0: write at base (s=0) with cfg_err; held through LOAD entry.
    vecs.push_back(mk(4'b0100, 1, 0, 1, 8'h40, o1, 0, 8'h40, 1, 0, 1));
    vecs.push_back(mk(4'b0010, 0, 1, 0, 8'h40, o1, 8, 8'h00, 1, 0, 1));
    vecs.push_back(mk(4'b0000, 0, 0, 0, 8'h00, o1, 8, 8'h00, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].fsm, vecs[i].wr_en, vecs[i].sin, vecs[i].cyc,
            vecs[i].base, vecs[i].off, vecs[i].z);
      tick();
      check_all($sformatf("vec%0d", i), int'(vecs[i].e_addr), int'(vecs[i].e_wr),
                int'(vecs[i].e_done), int'(vecs[i].e_err));
    end

    // ---------------- reset mid-UPDATE ----------------
    drive(4'b0100, 1'b1, 1'b0, 2'd1, 8'h20, o1, 8'd8);
    tick();
    bus.cycle = 2'd2; tick();
    bus.cycle = 2'd3; tick();
    bus.cycle = 2'd1; tick();
    check_all("rot1", 8'h26, 1, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0);
    #2;
    reset_n = 1'b1;
    tick();
    check_all("rot_restart", 8'h25, 1, 0, 0);

    // ---------------- randomized traffic vs. model ----------------
    for (int seg = 0; seg < 3; seg++) begin
      drive(4'b0000, 1'b0, 1'b0, 2'd0, 8'h00, 24'h0, 8'd1);
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      model_reset();
      z = (seg == 2) ? int'($urandom_range(200, 255)) : int'($urandom_range(1, 12));
      for (int k = 0; k < 3; k++) begin
        int o;
        o = int'($urandom_range(0, z + 1));
        if (o > 255) o = 255;
        offs[8*k +: 8] = 8'(o);
      end
      cur_mode = 0;
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 7) == 0) cur_mode = int'($urandom_range(0, 2));
        f = 4'($urandom_range(0, 15));
        if (cur_mode == 1)      f[1] = 1'b1;
        else if (cur_mode == 2) begin f[1] = 1'b0; f[2] = 1'b1; end
        else                    begin f[1] = 1'b0; f[2] = 1'b0; end
        drive(f, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), 8'($urandom), offs, 8'(z));
        model_step();
        tick();
        check_all("rnd", e_addr, e_wr, e_done, e_err);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
